// File: rtl/ir_key_queue_pkg.sv
// ir_pkg: shared widths and press-FSM encoding for the IR key queue.
package ir_pkg;
    localparam int IR_ADDR_W = 8;
    localparam int IR_CODE_W = 8;
    typedef enum logic {IR_IDLE = 1'b0, IR_HELD = 1'b1} ir_state_e;
endpackage

// File: rtl/ir_key_queue_if.sv
// ir_key_queue_if: receiver inputs, key event handshake and status of the IR key queue.
interface ir_key_queue_if;
    import ir_pkg::*;
    logic [IR_ADDR_W-1:0] address;
    logic [IR_CODE_W-1:0] data;
    logic                 data_ready;
    logic                 error;
    logic [IR_CODE_W-1:0] key_code;
    logic                 key_repeat;
    logic                 key_valid;
    logic                 key_ready;
    logic                 overflow;
    logic                 clear_overflow;
    logic [7:0]           error_count;
    modport master (
        output address, data, data_ready, error, key_ready, clear_overflow,
        input  key_code, key_repeat, key_valid, overflow, error_count
    );
    modport slave (
        input  address, data, data_ready, error, key_ready, clear_overflow,
        output key_code, key_repeat, key_valid, overflow, error_count
    );
endinterface

// File: rtl/ir_key_fifo.sv
// ir_key_fifo: synchronous first-word fall-through FIFO, power-of-2 depth.
module ir_key_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_wr, do_rd;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign do_rd   = rd_en & ~empty;
    // a full FIFO still takes a write when the head leaves in the same cycle
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_q[rptr_q];
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/ir_key_queue.sv
// ir_key_queue: filters NEC frames by address, tags hold-repeats and queues key events.
module ir_key_queue
    import ir_pkg::*;
#(
    parameter int                   CLOCKS_PER_MS    = 1000,
    parameter int                   REPEAT_WINDOW_MS = 150,
    parameter int                   FIFO_DEPTH       = 4,
    parameter bit                   ADDR_FILTER_EN   = 1'b1,
    parameter logic [IR_ADDR_W-1:0] DEVICE_ADDR      = 8'h00
) (
    input logic           clock,
    input logic           reset,
    ir_key_queue_if.slave bus
);
    localparam int PRE_W = $clog2(CLOCKS_PER_MS) + 1;
    localparam int CNT_W = $clog2(REPEAT_WINDOW_MS) + 1;
    ir_state_e            state_q, state_d;
    logic [IR_CODE_W-1:0] last_code_q, last_code_d;
    logic [PRE_W-1:0]     ms_pre_q, ms_pre_d;
    logic [CNT_W-1:0]     ms_cnt_q, ms_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 err_prev_q;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 accept, err_edge, expired, rep, pop, drop, full, empty;
    logic [IR_CODE_W:0]   head;
    assign accept   = bus.data_ready & (!ADDR_FILTER_EN || bus.address == DEVICE_ADDR);
    assign err_edge = bus.error & ~err_prev_q;
    assign expired  = ms_cnt_q == CNT_W'(REPEAT_WINDOW_MS);
    assign rep      = state_q == IR_HELD && bus.data == last_code_q;
    assign pop      = ~empty & bus.key_ready;
    assign drop     = accept & full & ~pop;
    always_comb begin
        state_d = state_q;
        if (accept) state_d = err_edge ? IR_IDLE : IR_HELD;
        else if (state_q == IR_HELD && (expired || err_edge)) state_d = IR_IDLE;
    end
    // ms_cnt freezes once it reaches the window so expiry holds until the next accept
    always_comb begin
        last_code_d = accept ? bus.data : last_code_q;
        ms_pre_d    = accept || expired ? ms_pre_q & {PRE_W{~accept}}
                    : ms_pre_q == PRE_W'(CLOCKS_PER_MS - 1) ? '0 : ms_pre_q + 1'b1;
        ms_cnt_d    = accept ? '0
                    : !expired && ms_pre_q == PRE_W'(CLOCKS_PER_MS - 1) ? ms_cnt_q + 1'b1 : ms_cnt_q;
        overflow_d  = drop ? 1'b1 : bus.clear_overflow ? 1'b0 : overflow_q;
        err_cnt_d   = err_edge && err_cnt_q != 8'hFF ? err_cnt_q + 1'b1 : err_cnt_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IR_IDLE;
            last_code_q <= '0;
            ms_pre_q    <= '0;
            ms_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            err_prev_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_code_q <= last_code_d;
            ms_pre_q    <= ms_pre_d;
            ms_cnt_q    <= ms_cnt_d;
            overflow_q  <= overflow_d;
            err_prev_q  <= bus.error;
            err_cnt_q   <= err_cnt_d;
        end
    end
    ir_key_fifo #(.WIDTH(IR_CODE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data ({rep, bus.data}),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .full    (full)
    );
    assign bus.key_valid   = ~empty;
    assign bus.key_code    = empty ? '0 : head[IR_CODE_W-1:0];
    assign bus.key_repeat  = ~empty & head[IR_CODE_W];
    assign bus.overflow    = overflow_q;
    assign bus.error_count = err_cnt_q;
endmodule

// File: tb/tb_ir_key_queue.sv
// tb_ir_key_queue: directed vectors and corner sequences for the IR key queue.
module tb_ir_key_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    ir_key_queue_if bus();
    ir_key_queue #(
        .CLOCKS_PER_MS    (10),
        .REPEAT_WINDOW_MS (5),
        .FIFO_DEPTH       (4),
        .ADDR_FILTER_EN   (1'b1),
        .DEVICE_ADDR      (8'h00)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        int         gap;
        logic [7:0] addr;
        logic [7:0] code;
        logic       ev;
        logic [7:0] exp_code;
        logic       exp_rep;
    } vec_t;
    vec_t vecs [8];
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
        bus.address    = a;
        bus.data       = c;
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
    endtask
    task automatic pop_one();
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
    endtask
    task automatic check_head(input string name, input logic [7:0] code, input logic rep);
        check({name, ".valid"}, 16'(bus.key_valid), 16'd1);
        check({name, ".code"}, 16'(bus.key_code), 16'(code));
        check({name, ".rep"}, 16'(bus.key_repeat), 16'(rep));
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        vecs[0] = '{0,  8'h00, 8'h45, 1'b1, 8'h45, 1'b0};
        vecs[1] = '{20, 8'h00, 8'h45, 1'b1, 8'h45, 1'b1};
        vecs[2] = '{20, 8'h00, 8'h45, 1'b1, 8'h45, 1'b1};
        vecs[3] = '{60, 8'h00, 8'h45, 1'b1, 8'h45, 1'b0};
        vecs[4] = '{10, 8'h00, 8'h46, 1'b1, 8'h46, 1'b0};
        vecs[5] = '{5,  8'h01, 8'h45, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{5,  8'h00, 8'h46, 1'b1, 8'h46, 1'b1};
        vecs[7] = '{5,  8'h00, 8'h47, 1'b1, 8'h47, 1'b0};
        rst = 1'b1;
        bus.address = '0;
        bus.data = '0;
        bus.data_ready = 1'b0;
        bus.error = 1'b0;
        bus.key_ready = 1'b0;
        bus.clear_overflow = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset.valid", 16'(bus.key_valid), 16'd0);
        check("reset.code", 16'(bus.key_code), 16'd0);
        check("reset.rep", 16'(bus.key_repeat), 16'd0);
        check("reset.ovf", 16'(bus.overflow), 16'd0);
        check("reset.errcnt", 16'(bus.error_count), 16'd0);
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].gap);
            send_frame(vecs[i].addr, vecs[i].code);
            if (vecs[i].ev) begin
                check_head($sformatf("vec%0d", i), vecs[i].exp_code, vecs[i].exp_rep);
                pop_one();
            end
            check($sformatf("vec%0d.empty", i), 16'(bus.key_valid), 16'd0);
        end
        // overflow: five back-to-back accepts into a 4-deep queue
        tick(60);
        for (int i = 0; i < 5; i++) send_frame(8'h00, 8'h10 + 8'(i));
        check("ovf.set", 16'(bus.overflow), 16'd1);
        check_head("ovf.head", 8'h10, 1'b0);
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        check("ovf.clear", 16'(bus.overflow), 16'd0);
        bus.key_ready = 1'b1;
        send_frame(8'h00, 8'h15);
        bus.key_ready = 1'b0;
        check("ovf.push_pop", 16'(bus.overflow), 16'd0);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), i == 3 ? 8'h15 : 8'h11 + 8'(i), 1'b0);
            pop_one();
        end
        check("drain.empty", 16'(bus.key_valid), 16'd0);
        // push into an empty queue while key_ready is already high: no bypass
        bus.key_ready = 1'b1;
        send_frame(8'h00, 8'h20);
        check_head("nobypass", 8'h20, 1'b0);
        tick();
        bus.key_ready = 1'b0;
        check("nobypass.popped", 16'(bus.key_valid), 16'd0);
        // error edge forces the next identical code to be a new press
        tick(60);
        send_frame(8'h00, 8'h45);
        check_head("err.first", 8'h45, 1'b0);
        pop_one();
        tick(2);
        bus.error = 1'b1;
        tick(3);
        bus.error = 1'b0;
        tick(3);
        send_frame(8'h00, 8'h45);
        check_head("err.second", 8'h45, 1'b0);
        pop_one();
        check("err.count1", 16'(bus.error_count), 16'd1);
        for (int i = 0; i < 253; i++) begin
            bus.error = 1'b1;
            tick();
            bus.error = 1'b0;
            tick();
        end
        check("err.countFE", 16'(bus.error_count), 16'h00FE);
        for (int i = 0; i < 46; i++) begin
            bus.error = 1'b1;
            tick();
            bus.error = 1'b0;
            tick();
        end
        check("err.sat", 16'(bus.error_count), 16'h00FF);
        // reset with events queued and sticky state set
        for (int i = 0; i < 5; i++) send_frame(8'h00, 8'h01 + 8'(i));
        check("rst.pre_ovf", 16'(bus.overflow), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst.valid", 16'(bus.key_valid), 16'd0);
        check("rst.ovf", 16'(bus.overflow), 16'd0);
        check("rst.errcnt", 16'(bus.error_count), 16'd0);
        send_frame(8'h00, 8'h04);
        check_head("rst.next", 8'h04, 1'b0);
        pop_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
